// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared states, view selects and ALU opcodes
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] V_RES  = 2'b00;
  localparam logic [1:0] V_OPA  = 2'b01;
  localparam logic [1:0] V_OPB  = 2'b10;
  localparam logic [1:0] V_SCAN = 2'b11;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;

endpackage

// File: rtl/alu_nbits.sv
// rtl/alu_nbits.sv - N-bit ALU with invert-B, carry-in and carry-out
module ALUNBits
  import alu_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  input  logic         invert_i,
  input  logic [2:0]   operacion_i,
  output logic [N-1:0] result_o,
  output logic         c_o
);

  logic [N-1:0] b_eff;
  logic [N:0]   sum;

  // Carry is only meaningful for ADD; logic ops report carry 0
  always_comb begin
    b_eff    = invert_i ? ~b_i : b_i;
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {{N{1'b0}}, c_i};
    result_o = '0;
    c_o      = 1'b0;
    case (operacion_i)
      OP_AND:  result_o = a_i & b_eff;
      OP_OR:   result_o = a_i | b_eff;
      OP_ADD: begin
        result_o = sum[N-1:0];
        c_o      = sum[N];
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/disp7segs.sv
// rtl/disp7segs.sv - hex nibble to active-high {g,f,e,d,c,b,a} segments
module Disp7segs (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Hex glyph table
  always_comb begin
    seg_o = 7'h00;
    case (nibble_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      default: seg_o = 7'h71;
    endcase
  end

endmodule

// File: rtl/memoria_a.sv
// rtl/memoria_a.sv - operand A constant ROM
module memoria_a #(
  parameter int N      = 32,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [N-1:0]      data_o
);

  // Small fixed operand image used by the board demo
  always_comb begin
    data_o = '0;
    case (addr_i)
      ADDR_W'(1): data_o = N'(32'h0000_0005);
      ADDR_W'(2): data_o = N'(32'h0000_0003);
      ADDR_W'(3): data_o = N'(32'hFFFF_FFFF);
      default:    data_o = '0;
    endcase
  end

endmodule

// File: rtl/memoria_b.sv
// rtl/memoria_b.sv - operand B constant ROM
module memoria_b #(
  parameter int N      = 32,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [N-1:0]      data_o
);

  // Small fixed operand image used by the board demo
  always_comb begin
    data_o = '0;
    case (addr_i)
      ADDR_W'(1): data_o = N'(32'h0000_0005);
      ADDR_W'(2): data_o = N'(32'h0000_0003);
      ADDR_W'(3): data_o = N'(32'h0000_0001);
      default:    data_o = '0;
    endcase
  end

endmodule

// File: rtl/view_scanner.sv
// rtl/view_scanner.sv - view select with timed auto-rotation
module view_scanner
  import alu_seq_pkg::*;
#(
  parameter int SCAN_DIV = 25_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] sel_i,
  output logic [1:0] view_o
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    scan_q, scan_d;

  // Counter only runs in auto-scan; leaving it restarts the rotation at the result view
  always_comb begin
    cnt_d  = '0;
    scan_d = V_RES;
    if (sel_i == V_SCAN) begin
      cnt_d  = cnt_q + 1'b1;
      scan_d = scan_q;
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
        cnt_d  = '0;
        scan_d = (scan_q == V_OPB) ? V_RES : scan_q + 2'd1;
      end
    end
  end

  // Counter and rotation registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      scan_q <= V_RES;
    end else begin
      cnt_q  <= cnt_d;
      scan_q <= scan_d;
    end
  end

  assign view_o = (sel_i == V_SCAN) ? scan_q : sel_i;

endmodule

// File: rtl/alu_seq_monitor.sv
// rtl/alu_seq_monitor.sv - sequenced ALU harness with accumulator, flags and display
module alu_seq_monitor
  import alu_seq_pkg::*;
#(
  parameter int N        = 32,
  parameter int ADDR_W   = 3,
  parameter int SCAN_DIV = 25_000_000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              acc_mode_i,
  input  logic [ADDR_W-1:0] addra_i,
  input  logic [ADDR_W-1:0] addrb_i,
  input  logic              c_i,
  input  logic              invert_i,
  input  logic [2:0]        operacion_i,
  input  logic [1:0]        seloperacion_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic              c_o,
  output logic              zero_o,
  output logic [1:0]        view_o,
  output logic [7*(N/4)-1:0] disp_o
);

  localparam int ND = N / 4;

  state_e       state_q, state_d;
  logic         start_q;
  logic [N-1:0] opa_q, opb_q, acc_q, result_q;
  logic         c_q, zero_q;
  logic         fetch_en, exec_en, clr_en;
  logic [N-1:0] rom_a, rom_b, alu_res, view_val;
  logic         alu_c;
  logic         start_rise;

  assign start_rise = start_i & ~start_q;

  memoria_a #(.N(N), .ADDR_W(ADDR_W)) u_rom_a (.addr_i(addra_i), .data_o(rom_a));
  memoria_b #(.N(N), .ADDR_W(ADDR_W)) u_rom_b (.addr_i(addrb_i), .data_o(rom_b));

  ALUNBits #(.N(N)) u_alu (
    .a_i        (opa_q),
    .b_i        (opb_q),
    .c_i        (c_i),
    .invert_i   (invert_i),
    .operacion_i(operacion_i),
    .result_o   (alu_res),
    .c_o        (alu_c)
  );

  // Next state and per-state enables; clear is only honoured when no operation is in flight
  always_comb begin
    state_d  = state_q;
    fetch_en = 1'b0;
    exec_en  = 1'b0;
    clr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        clr_en = clear_i;
        if (start_rise) state_d = FETCH;
      end
      FETCH: begin
        fetch_en = 1'b1;
        state_d  = EXEC;
      end
      EXEC: begin
        exec_en = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        clr_en  = clear_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Operands, accumulator, result and flags
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      start_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      start_q <= start_i;
      if (fetch_en) begin
        opa_q <= acc_mode_i ? acc_q : rom_a;
        opb_q <= rom_b;
      end
      if (exec_en) begin
        result_q <= alu_res;
        acc_q    <= alu_res;
        c_q      <= alu_c;
        zero_q   <= (alu_res == '0);
      end else if (clr_en) begin
        result_q <= '0;
        acc_q    <= '0;
        c_q      <= 1'b0;
        zero_q   <= 1'b1;
      end
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign valid_o = (state_q == DONE);
  assign c_o     = c_q;
  assign zero_o  = zero_q;

  view_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .sel_i  (seloperacion_i),
    .view_o (view_o)
  );

  // Value behind the current view; operand B follows the live invert switch
  always_comb begin
    view_val = result_q;
    case (view_o)
      V_OPA:   view_val = opa_q;
      V_OPB:   view_val = invert_i ? ~opb_q : opb_q;
      default: view_val = result_q;
    endcase
  end

  for (genvar k = 0; k < ND; k++) begin : g_digit
    Disp7segs u_seg (
      .nibble_i(view_val[4*k+3 -: 4]),
      .seg_o   (disp_o[7*k+6 -: 7])
    );
  end

endmodule

// File: tb/tb_alu_seq_monitor.sv
// tb/tb_alu_seq_monitor.sv - directed self-checking bench for alu_seq_monitor
module tb_alu_seq_monitor;

  logic        clk = 1'b0;
  logic        rst_n, start, clear, acc_mode, c_in, invert;
  logic [2:0]  addra, addrb, op;
  logic [1:0]  sel;
  logic        busy, valid, c_out, zero;
  logic [1:0]  view;
  logic [55:0] disp;

  int n_chk  = 0;
  int n_fail = 0;
  int vcount;

  always #5 clk = ~clk;

  alu_seq_monitor #(.N(32), .ADDR_W(3), .SCAN_DIV(4)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .clear_i       (clear),
    .acc_mode_i    (acc_mode),
    .addra_i       (addra),
    .addrb_i       (addrb),
    .c_i           (c_in),
    .invert_i      (invert),
    .operacion_i   (op),
    .seloperacion_i(sel),
    .busy_o        (busy),
    .valid_o       (valid),
    .c_o           (c_out),
    .zero_o        (zero),
    .view_o        (view),
    .disp_o        (disp)
  );

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [55:0] exp_disp(input logic [31:0] v);
    logic [55:0] d;
    for (int k = 0; k < 8; k++) d[7*k +: 7] = seg(v[4*k +: 4]);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [31:0] res, input logic cy, input logic z);
    start = 1'b1;
    tick();
    chk({tag, "_busy_fetch"}, 64'(busy), 64'd1);
    start = 1'b0;
    tick();
    chk({tag, "_valid_exec"}, 64'(valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(valid), 64'd1);
    chk({tag, "_disp"}, 64'(disp), 64'(exp_disp(res)));
    chk({tag, "_c"}, 64'(c_out), 64'(cy));
    chk({tag, "_zero"}, 64'(zero), 64'(z));
    tick();
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_valid"}, 64'(valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; acc_mode = 1'b0;
    c_in = 1'b0; invert = 1'b0; addra = 3'd0; addrb = 3'd0; op = 3'b010; sel = 2'b00;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_c", 64'(c_out), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_view", 64'(view), 64'd0);
    chk("rst_disp", 64'(disp), 64'(exp_disp(32'h0)));
    rst_n = 1'b1;
    tick();

    // 5 + 3
    addra = 3'd1; addrb = 3'd2;
    do_op("add", 32'h8, 1'b0, 1'b0);

    // 5 - 5 and 3 - 5
    invert = 1'b1; c_in = 1'b1; addra = 3'd1; addrb = 3'd1;
    do_op("sub_eq", 32'h0, 1'b1, 1'b1);
    addra = 3'd2;
    do_op("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);
    sel = 2'b10;
    #1 chk("view_opb_inv", 64'(disp), 64'(exp_disp(32'hFFFF_FFFA)));
    invert = 1'b0;
    #1 chk("view_opb", 64'(disp), 64'(exp_disp(32'h5)));
    sel = 2'b01;
    #1 chk("view_opa", 64'(disp), 64'(exp_disp(32'h3)));
    chk("view_sel01", 64'(view), 64'd1);
    sel = 2'b00; c_in = 1'b0;

    // Accumulator mode
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_disp", 64'(disp), 64'(exp_disp(32'h0)));
    chk("clr_zero", 64'(zero), 64'd1);
    acc_mode = 1'b1; addrb = 3'd2;
    do_op("acc1", 32'h3, 1'b0, 1'b0);
    do_op("acc2", 32'h6, 1'b0, 1'b0);
    do_op("acc3", 32'h9, 1'b0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_idle_disp", 64'(disp), 64'(exp_disp(32'h0)));
    chk("clr_idle_zero", 64'(zero), 64'd1);

    // Clear in FETCH and EXEC is ignored
    start = 1'b1;
    tick();
    start = 1'b0; clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    chk("clr_busy_disp", 64'(disp), 64'(exp_disp(32'h3)));
    chk("clr_busy_valid", 64'(valid), 64'd1);
    tick();

    // Second rise while busy is dropped; held start runs once
    acc_mode = 1'b0; addra = 3'd1; addrb = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid) vcount++;
    end
    chk("busy_valid_count", 64'(vcount), 64'd1);
    chk("held_start_idle", 64'(busy), 64'd0);
    chk("busy_result", 64'(disp), 64'(exp_disp(32'h8)));
    start = 1'b0;
    tick();

    // Reset during EXEC
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstop_busy", 64'(busy), 64'd0);
    chk("rstop_valid", 64'(valid), 64'd0);
    chk("rstop_disp", 64'(disp), 64'(exp_disp(32'h0)));
    chk("rstop_zero", 64'(zero), 64'd1);
    rst_n = 1'b1;
    tick();
    chk("rstop_valid2", 64'(valid), 64'd0);

    // Auto-scan rotation
    sel = 2'b11;
    #1;
    for (int i = 0; i <= 12; i++) begin
      chk($sformatf("scan_%0d", i), 64'(view), 64'((i / 4) % 3));
      if (i < 12) tick();
    end
    for (int i = 0; i < 5; i++) tick();
    chk("scan_pre_leave", 64'(view), 64'd1);
    sel = 2'b01;
    #1 chk("leave_view", 64'(view), 64'd1);
    tick();
    sel = 2'b11;
    #1 chk("reenter_view", 64'(view), 64'd0);
    tick(); tick(); tick();
    chk("reenter_hold", 64'(view), 64'd0);
    tick();
    chk("reenter_adv", 64'(view), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
